// File: rtl/approx_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : approx_adder_error_monitor
// Brief    : Streaming error-metrics engine for approximate adders
// Revision : 1.0 - initial release
// ============================================================================
module approx_adder_error_monitor #(
    parameter int WIDTH       = 16,
    parameter int NUM_SAMPLES = 10000,
    parameter int ACC_W       = 32,
    parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [WIDTH:0]     approx_sum,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [ACC_W-1:0]   total_err,
    output logic [WIDTH:0]     max_err,
    output logic [CNT_W-1:0]   max_err_idx
);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_run   = 2'd1;
    localparam logic [1:0] c_s_drain = 2'd2;
    localparam logic [1:0] c_s_done  = 2'd3;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_drain_cnt;
    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_err_count;
    logic [ACC_W-1:0] r_total_err;
    logic [WIDTH:0]   r_max_err;
    logic [CNT_W-1:0] r_max_err_idx;

    logic             r_s1_valid;
    logic [WIDTH:0]   r_s1_exact;
    logic [WIDTH:0]   r_s1_approx;
    logic [CNT_W-1:0] r_s1_idx;
    logic             r_s2_valid;
    logic [WIDTH:0]   r_s2_diff;
    logic [CNT_W-1:0] r_s2_idx;

    logic             w_accept;
    logic [WIDTH:0]   w_exact;
    logic [WIDTH:0]   w_diff;
    logic [ACC_W:0]   w_total_sum;
    logic [ACC_W-1:0] w_total_next;

    assign w_accept = in_valid && (r_state == c_s_run);
    assign w_exact  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    // Compare first so the magnitude never wraps regardless of error sign
    assign w_diff   = (r_s1_exact >= r_s1_approx) ? (r_s1_exact - r_s1_approx)
                                                  : (r_s1_approx - r_s1_exact);
    assign w_total_sum  = {1'b0, r_total_err} + {{(ACC_W - WIDTH){1'b0}}, r_s2_diff};
    assign w_total_next = w_total_sum[ACC_W] ? {ACC_W{1'b1}} : w_total_sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_exact  <= '0;
            r_s1_approx <= '0;
            r_s1_idx    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_diff   <= '0;
            r_s2_idx    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_exact  <= w_exact;
                r_s1_approx <= approx_sum;
                r_s1_idx    <= r_sample_count;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_diff <= w_diff;
                r_s2_idx  <= r_s1_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_s_idle;
            r_drain_cnt    <= 1'b0;
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_total_err    <= '0;
            r_max_err      <= '0;
            r_max_err_idx  <= '0;
        end else begin
            if (r_s2_valid) begin
                if (r_s2_diff != '0) begin
                    r_err_count <= r_err_count + c_one;
                end
                r_total_err <= w_total_next;
                if (r_s2_diff > r_max_err) begin
                    r_max_err     <= r_s2_diff;
                    r_max_err_idx <= r_s2_idx;
                end
            end

            case (r_state)
                c_s_idle, c_s_done: begin
                    if (start) begin
                        r_state        <= c_s_run;
                        r_sample_count <= '0;
                        r_err_count    <= '0;
                        r_total_err    <= '0;
                        r_max_err      <= '0;
                        r_max_err_idx  <= '0;
                    end
                end
                c_s_run: begin
                    if (w_accept) begin
                        r_sample_count <= r_sample_count + c_one;
                        if (r_sample_count == c_last) begin
                            r_state     <= c_s_drain;
                            r_drain_cnt <= 1'b0;
                        end
                    end
                end
                c_s_drain: begin
                    // Two drain cycles cover both pipeline stages
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) begin
                        r_state <= c_s_done;
                    end
                end
                default: r_state <= c_s_idle;
            endcase
        end
    end

    assign in_ready     = (r_state == c_s_run);
    assign busy         = (r_state == c_s_run) || (r_state == c_s_drain);
    assign done         = (r_state == c_s_done);
    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;
    assign total_err    = r_total_err;
    assign max_err      = r_max_err;
    assign max_err_idx  = r_max_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_adder_error_monitor
// Brief    : Directed self-checking bench, WIDTH=16, NUM_SAMPLES=4, ACC_W=17
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_adder_error_monitor;

    localparam int c_width = 16;
    localparam int c_ns    = 4;
    localparam int c_acc_w = 17;
    localparam int c_cnt_w = $clog2(c_ns + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [c_width-1:0]   a = '0;
    logic [c_width-1:0]   b = '0;
    logic                 cin = 1'b0;
    logic [c_width:0]     approx_sum = '0;
    logic                 busy;
    logic                 done;
    logic [c_cnt_w-1:0]   sample_count;
    logic [c_cnt_w-1:0]   err_count;
    logic [c_acc_w-1:0]   total_err;
    logic [c_width:0]     max_err;
    logic [c_cnt_w-1:0]   max_err_idx;

    int n_cmp = 0;
    int n_mis = 0;

    approx_adder_error_monitor #(
        .WIDTH(c_width), .NUM_SAMPLES(c_ns), .ACC_W(c_acc_w)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .cin(cin), .approx_sum(approx_sum),
        .busy(busy), .done(done), .sample_count(sample_count),
        .err_count(err_count), .total_err(total_err), .max_err(max_err),
        .max_err_idx(max_err_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; the sample is taken at the next rising edge
    task automatic send(input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [16:0] vs);
        a = va; b = vb; cin = vc; approx_sum = vs; in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic open_window();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", in_ready, 1);
        check("start_busy", busy, 1);
        check("start_cnt", sample_count, 0);
        check("start_err", err_count, 0);
        check("start_tot", total_err, 0);
        check("start_max", max_err, 0);
    endtask

    task automatic close_window(input logic [31:0] e_err, input logic [31:0] e_tot,
                                input logic [31:0] e_max, input logic [31:0] e_idx);
        in_valid = 1'b0;
        check("drain_ready", in_ready, 0);
        check("drain_busy", busy, 1);
        check("drain_done0", done, 0);
        check("drain_cnt", sample_count, c_ns);
        @(negedge clk);
        check("drain_done1", done, 0);
        @(negedge clk);
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("err_count", err_count, e_err);
        check("total_err", total_err, e_tot);
        check("max_err", max_err, e_max);
        check("max_err_idx", max_err_idx, e_idx);
        @(negedge clk);
        check("done_hold", done, 1);
        check("hold_tot", total_err, e_tot);
    endtask

    initial begin
        // Reset and idle behaviour
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", sample_count, 0);
        check("rst_err", err_count, 0);
        check("rst_tot", total_err, 0);
        check("rst_max", max_err, 0);
        check("rst_idx", max_err_idx, 0);
        repeat (3) send(16'd1, 16'd2, 1'b0, 17'd9);
        in_valid = 1'b0;
        check("idle_cnt", sample_count, 0);
        check("idle_ready", in_ready, 0);

        // Exact adder, back-to-back
        open_window();
        send(16'd10, 16'd20, 1'b0, 17'd30);
        send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        send(16'd0, 16'd0, 1'b0, 17'd0);
        send(16'd1234, 16'd4321, 1'b1, 17'd5556);
        close_window(0, 0, 0, 0);

        // Mixed errors, restart from DONE, start in RUN ignored, one gap
        open_window();
        send(16'd1, 16'd1, 1'b0, 17'd2);
        start = 1'b1;
        send(16'hFFFF, 16'd1, 1'b0, 17'h0FFFF);
        start = 1'b0;
        check("run_start_cnt", sample_count, 2);
        in_valid = 1'b0;
        @(negedge clk);
        check("gap_cnt", sample_count, 2);
        send(16'd5, 16'd3, 1'b1, 17'd10);
        send(16'd100, 16'd0, 1'b0, 17'd90);
        close_window(3, 12, 10, 3);

        // Over-estimates with a tie at max: earliest index kept
        open_window();
        send(16'd3, 16'd4, 1'b0, 17'd9);
        send(16'd10, 16'd0, 1'b0, 17'd17);
        send(16'd20, 16'd0, 1'b1, 17'd28);
        send(16'd5, 16'd5, 1'b0, 17'd10);
        close_window(3, 16, 7, 1);

        // Accumulator saturation at ACC_W=17
        open_window();
        repeat (4) send(16'hFFFF, 16'hFFFF, 1'b1, 17'd0);
        close_window(4, 32'h1FFFF, 32'h1FFFF, 0);

        // Reset mid-window, with start held alongside rst
        open_window();
        repeat (3) send(16'd7, 16'd0, 1'b0, 17'd0);
        check("mid_cnt", sample_count, 3);
        in_valid = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("mid_rst_cnt", sample_count, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_tot", total_err, 0);
        check("mid_rst_max", max_err, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 0);
        check("post_rst_err", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/approx_adder_error_monitor.md
# approx_adder_error_monitor

Synthesizable, streaming error-metrics engine for approximate adders. Receives operand pairs plus the DUT's approximate sum, computes the exact sum internally, and accumulates error count, total error distance, maximum error distance and the index of the first maximum over a programmable sample window. It is the parametrised, hardware-resident successor to the bench-only error tally: it sits beside any approximate adder (Brent-Kung, Kogge-Stone, Sklansky variants) in an FPGA characterisation harness or in a self-checking bench.

## Interface

- WIDTH, 16, operand width; sums are WIDTH+1 bits
- NUM_SAMPLES, 10000, samples per measurement window (>= 1)
- ACC_W, 32, width of total_err accumulator (>= WIDTH+1)
- CNT_W, $clog2(NUM_SAMPLES+1), width of counters and index

- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  pulse: clear statistics and open a window
- in_valid  in  1  sample present
- in_ready  out  1  monitor accepts sample this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- approx_sum  in  WIDTH+1  DUT sum, MSB is carry-out
- busy  out  1  window open or draining
- done  out  1  results final and stable
- sample_count  out  CNT_W  samples accepted in current window
- err_count  out  CNT_W  samples with approx_sum != exact sum
- total_err  out  ACC_W  sum of |exact - approx|, saturating
- max_err  out  WIDTH+1  largest |exact - approx|
- max_err_idx  out  CNT_W  0-based index of first sample reaching max_err

## Operation

- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. start -> clear all statistics, go RUN.
- RUN: in_ready=1. Accept on in_valid && in_ready; sample_count increments. When accepting sample number NUM_SAMPLES (count reaches NUM_SAMPLES) -> DRAIN. start in RUN is ignored.
- DRAIN: in_ready=0; two cycles, pipeline flushes -> DONE.
- DONE: done=1, all outputs held. start -> clear statistics, go RUN (no pass through IDLE).
- Arithmetic: exact = a + b + cin at WIDTH+1 bits (no loss). diff = |exact - approx_sum| at WIDTH+1 bits, computed by compare-then-subtract, never wrapping.
- err_count increments iff diff != 0.
- total_err += diff, zero-extended to ACC_W; saturates at all-ones, never wraps.
- max_err/max_err_idx update only when diff > max_err (strict); ties keep earliest index. Index is the sample's acceptance ordinal (0 for first).
- Samples offered when in_ready=0 are not consumed and not counted.
- busy = (state is RUN or DRAIN).

## Timing

- Reset: state IDLE; in_ready, busy, done = 0; sample_count, err_count, total_err, max_err, max_err_idx = 0. Reset mid-window discards in-flight samples and all partial results.
- Pipeline: stage 1 registers exact, approx_sum, index at acceptance edge N; stage 2 registers diff at N+1; statistics update at N+2. Latency 2 cycles per sample, throughput 1 sample/cycle.
- sample_count updates at acceptance edge; other statistics lag by 2 cycles.
- Last sample accepted at edge N: state DRAIN from N; done=1 and statistics final from edge N+2.
- start clears statistics at the same edge that enters RUN; in_ready=1 the following cycle.
- start asserted simultaneously with rst: rst wins.
- NUM_SAMPLES=1: one accept, then DRAIN, done 2 cycles later.

## Test plan

- Reset then idle: outputs all zero, in_ready=0 after rst; in_valid pulses ignored, sample_count stays 0.
- Exact DUT model, NUM_SAMPLES=4, back-to-back samples: done 2 cycles after 4th accept; err_count=0, total_err=0, max_err=0, max_err_idx=0.
- WIDTH=16, samples (a,b,cin,approx): (1,1,0,2), (0xFFFF,1,0,0x0FFFF), (5,3,1,10), (100,0,0,90): exact 2, 0x10000, 9, 100 -> diffs 0, 1, 1, 10; err_count=3, total_err=12, max_err=10, max_err_idx=3.
- Tie and over-estimate: diffs 7 at idx 1 and 7 at idx 2 (approx > exact) -> max_err=7, max_err_idx=1.
- ACC_W=17, four samples each diff 0x1FFFF -> total_err saturates at 0x1FFFF, no wrap.
- rst asserted during RUN after 3 accepts -> all outputs zero next cycle; start in DONE restarts window with cleared stats; start during RUN ignored; in_valid gaps do not change results.
